spi_arbiter: RTL and testbench

Shares the single `spi_ctrl` byte-transfer engine between two requesters: requester 0 is the CPU peripheral-bus path and requester 1 is an auxiliary hardware master, such as a display refresh engine. A requester owns the controller for a whole SPI transaction, meaning every byte up to and including the one flagged end-of-transaction. During that time the other requester cannot interleave bytes under the same chip select. The arbiter sits between the peripheral address decode and `spi_ctrl`, driving its start/data/dc/end_txn inputs and returning read bytes to the owning requester.

---
 rtl/spi_arbiter_if.sv | 21 ++
 rtl/spi_arbiter.sv | 67 ++++++
 tb/tb_spi_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester-side byte/response bus of spi_arbiter
// req_valid/req_data0/req_data1/req_dc/req_end: byte offered by requester 0/1
// req_ready: byte accepted this cycle; rsp_valid/rsp_data: completed byte returned to its owner
interface spi_arbiter_if;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_dc;
  logic [1:0] req_end;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  modport master (
    output req_valid, req_data0, req_data1, req_dc, req_end,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_data0, req_data1, req_dc, req_end,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_ctrl byte engine between two requesters, one whole transaction per grant
// clk/rst: clock, sync active-high reset; bus: requester bytes in, ready and read-back responses out
// spi_start/spi_data/spi_dc/spi_end_txn: to spi_ctrl; spi_busy/spi_rdata: from spi_ctrl
// owner: current/last granted requester; locked: owner holds the controller until its end byte
module spi_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic         clk,
  input  logic         rst,
  spi_arbiter_if.slave bus,
  output logic         spi_start,
  output logic [7:0]   spi_data,
  output logic         spi_dc,
  output logic         spi_end_txn,
  input  logic         spi_busy,
  input  logic [7:0]   spi_rdata,
  output logic         owner,
  output logic         locked
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic last, gnt, acc;
  // an open transaction pins the grant to its owner; a tie alternates away from the last winner
  always_comb begin
    gnt = locked ? owner : (&bus.req_valid ? (ROUND_ROBIN != 0 ? ~last : 1'b0) : bus.req_valid[1]);
    acc = state == IDLE && bus.req_valid[gnt];
  end
  assign bus.req_ready = acc ? {gnt, ~gnt} : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      owner         <= 1'b0;
      locked        <= 1'b0;
      spi_start     <= 1'b0;
      spi_data      <= 8'h00;
      spi_dc        <= 1'b0;
      spi_end_txn   <= 1'b0;
      bus.rsp_valid <= 2'b00;
      bus.rsp_data  <= 8'h00;
    end else begin
      spi_start     <= 1'b0;
      bus.rsp_valid <= 2'b00;
      case (state)
        IDLE: if (acc) begin
          spi_data    <= gnt ? bus.req_data1 : bus.req_data0;
          spi_dc      <= bus.req_dc[gnt];
          spi_end_txn <= bus.req_end[gnt];
          owner       <= gnt;
          last        <= gnt;
          // the lock drops as soon as the end byte is taken, not when it completes
          locked      <= ~bus.req_end[gnt];
          spi_start   <= 1'b1;
          state       <= ISSUE;
        end
        // spi_ctrl raises busy the cycle after start, so busy is only meaningful from WAIT on
        ISSUE: state <= WAIT;
        WAIT: if (!spi_busy) begin
          bus.rsp_data  <= spi_rdata;
          bus.rsp_valid <= {owner, ~owner};
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized and directed checks of spi_arbiter (round-robin and fixed-priority) against a transaction-level model
module tb_spi_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [1:0] rv = 2'b00, rdc = 2'b00, re = 2'b00;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, rdata = 8'h00;
  logic [1:0] st, sdc, se, own, lk;
  logic [1:0] busy = 2'b00;
  logic [7:0] sd0, sd1, rspd0, rspd1;
  logic [1:0] rdy0, rdy1, rspv0, rspv1;
  spi_arbiter_if bus0 ();
  spi_arbiter_if bus1 ();
  assign bus0.req_valid = rv;
  assign bus0.req_data0 = d0;
  assign bus0.req_data1 = d1;
  assign bus0.req_dc    = rdc;
  assign bus0.req_end   = re;
  assign bus1.req_valid = rv;
  assign bus1.req_data0 = d0;
  assign bus1.req_data1 = d1;
  assign bus1.req_dc    = rdc;
  assign bus1.req_end   = re;
  assign rdy0  = bus0.req_ready;
  assign rdy1  = bus1.req_ready;
  assign rspv0 = bus0.rsp_valid;
  assign rspv1 = bus1.rsp_valid;
  assign rspd0 = bus0.rsp_data;
  assign rspd1 = bus1.rsp_data;
  spi_arbiter #(.ROUND_ROBIN(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .spi_start(st[0]), .spi_data(sd0), .spi_dc(sdc[0]), .spi_end_txn(se[0]),
    .spi_busy(busy[0]), .spi_rdata(rdata), .owner(own[0]), .locked(lk[0])
  );
  spi_arbiter #(.ROUND_ROBIN(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .spi_start(st[1]), .spi_data(sd1), .spi_dc(sdc[1]), .spi_end_txn(se[1]),
    .spi_busy(busy[1]), .spi_rdata(rdata), .owner(own[1]), .locked(lk[1])
  );
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask
  // which requester the rules grant, -1 for none
  function automatic int pick(logic [1:0] v, bit l, bit o, bit lst, bit rr);
    if (l) return v[o] ? int'(o) : -1;
    if (v == 2'b00) return -1;
    if (v != 2'b11) return v[1] ? 1 : 0;
    return rr ? int'(!lst) : 0;
  endfunction
  // model: a byte accepted at cycle T starts at T+1 and completes on the first cycle >= T+2 with busy low
  bit chk_en = 1'b0;
  int cyc = 0;
  bit m_pend[2], m_own[2], m_lk[2], m_last[2], m_start[2], m_sdc[2], m_se[2];
  int m_from[2];
  bit [1:0] m_rspv[2];
  bit [7:0] m_rspd[2], m_sd[2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int g;
      g = m_pend[k] ? -1 : pick(rv, m_lk[k], m_own[k], m_last[k], k == 0);
      if (chk_en) begin
        chk("req_ready", k, 32'(k ? rdy1 : rdy0), g < 0 ? 32'd0 : (g == 1 ? 32'd2 : 32'd1));
        chk("spi_start", k, 32'(st[k]), 32'(m_start[k]));
        chk("spi_data", k, 32'(k ? sd1 : sd0), 32'(m_sd[k]));
        chk("spi_dc", k, 32'(sdc[k]), 32'(m_sdc[k]));
        chk("spi_end_txn", k, 32'(se[k]), 32'(m_se[k]));
        chk("owner", k, 32'(own[k]), 32'(m_own[k]));
        chk("locked", k, 32'(lk[k]), 32'(m_lk[k]));
        chk("rsp_valid", k, 32'(k ? rspv1 : rspv0), 32'(m_rspv[k]));
        chk("rsp_data", k, 32'(k ? rspd1 : rspd0), 32'(m_rspd[k]));
      end
      m_start[k] = 1'b0;
      m_rspv[k] = 2'b00;
      if (rst) begin
        m_pend[k] = 1'b0; m_own[k] = 1'b0; m_lk[k] = 1'b0; m_last[k] = 1'b1;
        m_sd[k] = 8'h00; m_sdc[k] = 1'b0; m_se[k] = 1'b0; m_rspd[k] = 8'h00;
      end else if (g >= 0) begin
        m_sd[k] = g == 1 ? d1 : d0;
        m_sdc[k] = rdc[g];
        m_se[k] = re[g];
        m_own[k] = g == 1;
        m_last[k] = g == 1;
        m_lk[k] = !re[g];
        m_start[k] = 1'b1;
        m_pend[k] = 1'b1;
        m_from[k] = cyc + 2;
      end else if (m_pend[k] && cyc >= m_from[k] && !busy[k]) begin
        m_rspd[k] = rdata;
        m_rspv[k] = m_own[k] ? 2'b10 : 2'b01;
        m_pend[k] = 1'b0;
      end
    end
    cyc++;
  end
  // observed start log for directed grant-order checks
  int mc = 0, dbl = 0;
  int gq0[$], gq1[$], sq0[$];
  logic [7:0] dq0[$];
  logic [1:0] pst = 2'b00;
  always @(negedge clk) begin
    if (chk_en) begin
      if (st[0]) begin gq0.push_back(int'(own[0])); sq0.push_back(mc); dq0.push_back(sd0); end
      if (st[1]) gq1.push_back(int'(own[1]));
      if ((st & pst) != 2'b00) dbl++;
    end
    pst = st;
    mc++;
  end
  // spi_ctrl stand-in: busy for blen (or random) cycles starting the cycle after start
  int blen = 4;
  bit noise = 1'b0, fixrd = 1'b1;
  int cnt[2] = '{0, 0};
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) cnt[k] = 0;
      busy[k] = cnt[k] > 0 || (noise && $urandom_range(0, 3) == 0);
      if (cnt[k] > 0) cnt[k]--;
      if (st[k]) cnt[k] = blen > 0 ? blen : int'($urandom_range(1, 5));
    end
    rdata = fixrd ? 8'h3C : 8'($urandom);
  endtask
  task automatic reset_dut();
    tick();
    rst = 1'b1;
    rv = 2'b00;
    tick();
    rst = 1'b0;
  endtask
  int n, n0, n1, viol;
  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ready", 0, 32'(rdy0), 0);
    chk("reset_locked", 0, 32'(lk[0]), 0);
    // single byte
    tick();
    rv = 2'b01; d0 = 8'hA5; re = 2'b01; rdc = 2'b00;
    #1;
    chk("t1_ready", 0, 32'(rdy0), 1);
    chk("t1_ready", 1, 32'(rdy1), 1);
    tick();
    rv = 2'b00;
    #1;
    chk("t1_start", 0, 32'(st[0]), 1);
    chk("t1_data", 0, 32'(sd0), 32'hA5);
    chk("t1_end", 0, 32'(se[0]), 1);
    n = 0;
    while (rspv0 == 2'b00 && n < 20) begin tick(); #1; n++; end
    chk("t1_rsp_valid", 0, 32'(rspv0), 1);
    chk("t1_rsp_data", 0, 32'(rspd0), 32'h3C);
    chk("t1_locked", 0, 32'(lk[0]), 0);
    chk("t1_latency", 0, 32'(n), 6);
    chk("t1_model_rspd", 0, 32'(m_rspd[0]), 32'h3C);
    // lock: req0 two-byte transaction while req1 waits
    reset_dut();
    gq0.delete(); gq1.delete(); dq0.delete();
    n0 = 0; n1 = 0; viol = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      rv = {n1 < 1, n0 < 2};
      d0 = n0 == 0 ? 8'h01 : 8'h02;
      re = {1'b1, n0 == 1};
      d1 = 8'h77;
      #1;
      if (rdy0[1] && n0 < 2) viol++;
      if (rdy0[0]) n0++;
      if (rdy0[1]) n1++;
    end
    chk("t2_req1_blocked", 0, 32'(viol), 0);
    chk("t2_grants", 0, 32'(gq0.size()), 3);
    chk("t2_grants", 1, 32'(gq1.size()), 3);
    if (gq0.size() == 3) begin
      chk("t2_owner_a", 0, 32'(gq0[0]), 0);
      chk("t2_owner_b", 0, 32'(gq0[1]), 0);
      chk("t2_owner_c", 0, 32'(gq0[2]), 1);
      chk("t2_third_byte", 0, 32'(dq0[2]), 32'h77);
    end
    // alternating vs fixed priority under continuous contention
    reset_dut();
    gq0.delete(); gq1.delete(); sq0.delete();
    rv = 2'b11; re = 2'b11; d0 = 8'hA0; d1 = 8'hB1;
    repeat (40) tick();
    rv = 2'b00;
    repeat (12) tick();
    chk("t3_rr_count", 0, 32'(gq0.size() >= 4), 1);
    chk("t3_fp_count", 1, 32'(gq1.size() >= 4), 1);
    if (gq0.size() >= 4 && gq1.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_rr_grant", 0, 32'(gq0[i]), 32'(i % 2));
        chk("t3_fp_grant", 1, 32'(gq1[i]), 0);
      end
      chk("t3_back_to_back", 0, 32'(sq0[1] - sq0[0]), 7);
    end
    // reset while req1 holds the lock in WAIT
    blen = 10;
    tick();
    rv = 2'b10; d1 = 8'h55; re = 2'b00;
    #1;
    chk("t4_ready", 0, 32'(rdy0), 2);
    chk("t4_ready", 1, 32'(rdy1), 2);
    tick();
    rv = 2'b00;
    tick();
    #1;
    chk("t4_locked", 0, 32'(lk[0]), 1);
    chk("t4_owner", 0, 32'(own[0]), 1);
    rst = 1'b1;
    rv = 2'b11;
    tick();
    rst = 1'b0;
    #1;
    chk("t4_rst_rspv", 0, 32'(rspv0), 0);
    chk("t4_rst_rspd", 0, 32'(rspd0), 0);
    chk("t4_rst_start", 0, 32'(st[0]), 0);
    chk("t4_rst_data", 0, 32'(sd0), 0);
    chk("t4_rst_owner", 0, 32'(own[0]), 0);
    chk("t4_rst_locked", 0, 32'(lk[0]), 0);
    chk("t4_first_grant", 0, 32'(rdy0), 1);
    chk("t4_first_grant", 1, 32'(rdy1), 1);
    tick();
    rv = 2'b00;
    repeat (30) tick();
    // idle owner keeps the lock while req1 waits
    tick();
    rv = 2'b01; d0 = 8'h11; re = 2'b00;
    #1;
    chk("t5_ready", 0, 32'(rdy0), 1);
    tick();
    rv = 2'b10;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      chk("t5_req1_blocked", 0, 32'(rdy0[1]), 0);
      chk("t5_locked", 0, 32'(lk[0]), 1);
    end
    reset_dut();
    // randomized traffic with noisy busy outside WAIT
    noise = 1'b1; blen = 0; fixrd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rv = 2'($urandom);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      rdc = 2'($urandom);
      re = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
    end
    rv = 2'b00;
    repeat (20) tick();
    chk("no_double_start", 0, 32'(dbl), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
